// File: rtl/mux_stream_arb.sv
// mux_stream_arb: N-channel valid/ready stream mux with packet locking.
// Selection is round-robin, fixed priority or manual (MODE). One output register.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_last    per-channel handshake valid and end-of-packet flag
//   in_data             channel i occupies bits [i*DW +: DW]
//   in_ready            per-channel ready, at most one bit high
//   sel                 channel select, used only when MODE=2
//   out_valid/data/last registered output beat
//   out_ch              source channel of the registered beat
//   out_ready           downstream ready
module mux_stream_arb #(
    parameter int N_CH = 4,
    parameter int DW   = 4,
    parameter int MODE = 0,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    in_valid,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    in_last,
    output logic [N_CH-1:0]    in_ready,
    input  logic [SELW-1:0]    sel,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic               out_last,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] g_q, g_d;
    logic [SELW-1:0] p_q, p_d;

    logic [SELW-1:0] arb_ch;
    logic            arb_ok;
    logic [SELW-1:0] g_eff;
    logic            elig;
    logic            ld;
    logic            acc;
    logic            beat_last;
    logic [DW-1:0]   beat_data;

    // Output register can take a new beat when empty or being drained.
    assign ld  = !out_valid || out_ready;
    assign acc = ld && elig;

    // Arbitration among idle channels.
    always_comb begin
        logic [SELW-1:0] ix;
        arb_ch = '0;
        arb_ok = 1'b0;
        ix     = '0;
        if (MODE == 0) begin
            // First valid channel starting at the round-robin pointer.
            for (int k = 0; k < N_CH; k++) begin
                ix = SELW'((int'(p_q) + k) % N_CH);
                if (!arb_ok && in_valid[ix]) begin
                    arb_ok = 1'b1;
                    arb_ch = ix;
                end
            end
        end else if (MODE == 1) begin
            // Descending scan so the lowest valid index is the last write.
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (in_valid[k]) begin
                    arb_ok = 1'b1;
                    arb_ch = SELW'(k);
                end
            end
        end else begin
            // Out-of-range select grants nobody.
            if (int'(sel) < N_CH) begin
                arb_ok = in_valid[sel];
                arb_ch = sel;
            end
        end
    end

    // Grant, FSM next state and per-channel ready.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        p_d      = p_q;
        g_eff    = arb_ch;
        elig     = arb_ok;
        in_ready = '0;

        unique case (state_q)
            IDLE: begin
                g_eff = arb_ch;
                elig  = arb_ok;
            end
            LOCK: begin
                g_eff = g_q;
                elig  = in_valid[g_q];
            end
            default: begin
                g_eff = arb_ch;
                elig  = arb_ok;
            end
        endcase

        if (ld && elig) begin
            in_ready[g_eff] = 1'b1;
        end

        if (acc) begin
            unique case (state_q)
                IDLE: begin
                    if (!in_last[g_eff]) begin
                        state_d = LOCK;
                        g_d     = g_eff;
                    end
                end
                LOCK: begin
                    if (in_last[g_eff]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Pointer advances past the channel that just finished a packet.
            if (MODE == 0 && in_last[g_eff]) begin
                if (int'(g_eff) == N_CH - 1) begin
                    p_d = '0;
                end else begin
                    p_d = g_eff + 1'b1;
                end
            end
        end
    end

    assign beat_last = in_last[g_eff];
    assign beat_data = in_data[int'(g_eff)*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (ld) begin
            out_valid <= acc;
            if (acc) begin
                out_data <= beat_data;
                out_last <= beat_last;
                out_ch   <= g_eff;
            end
        end
    end

endmodule

// File: tb/tb_mux_stream_arb.sv
// tb_mux_stream_arb: drives three mux_stream_arb instances (MODE 0/1/2)
// with shared stimulus and checks each against a per-mode reference model.
module tb_mux_stream_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_last;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0]  rdy [3];
    logic        ov  [3];
    logic [3:0]  od  [3];
    logic        ol  [3];
    logic [1:0]  och [3];

    logic        e_ov [3];
    logic [3:0]  e_od [3];
    logic        e_ol [3];
    logic [1:0]  e_ch [3];
    bit          lk   [3];
    int          mg   [3];
    int          mp   [3];

    int n_chk;
    int n_pass;

    mux_stream_arb #(.N_CH(4), .DW(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy[0]), .sel(sel),
        .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
        .out_ch(och[0]), .out_ready(out_ready)
    );

    mux_stream_arb #(.N_CH(4), .DW(4), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy[1]), .sel(sel),
        .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
        .out_ch(och[1]), .out_ready(out_ready)
    );

    mux_stream_arb #(.N_CH(4), .DW(4), .MODE(2)) u_ms (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy[2]), .sel(sel),
        .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]),
        .out_ch(och[2]), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic reset_model();
        for (int m = 0; m < 3; m++) begin
            e_ov[m] = 1'b0;
            e_od[m] = 4'h0;
            e_ol[m] = 1'b0;
            e_ch[m] = 2'd0;
            lk[m]   = 1'b0;
            mg[m]   = 0;
            mp[m]   = 0;
        end
    endtask

    // One clock: drive inputs, check every DUT against its model,
    // advance the model, then step to just past the next rising edge.
    task automatic cyc(input logic [3:0] v, input logic [15:0] d,
                       input logic [3:0] l, input logic [1:0] s,
                       input logic r);
        int         c;
        bit         ok;
        bit         ld;
        logic [3:0] er;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        sel       = s;
        out_ready = r;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("m%0d out_valid", m), 32'(ov[m]), 32'(e_ov[m]));
            chk($sformatf("m%0d out_data", m), 32'(od[m]), 32'(e_od[m]));
            chk($sformatf("m%0d out_last", m), 32'(ol[m]), 32'(e_ol[m]));
            chk($sformatf("m%0d out_ch", m), 32'(och[m]), 32'(e_ch[m]));
            ld = !e_ov[m] || r;
            ok = 1'b0;
            c  = 0;
            if (lk[m]) begin
                c  = mg[m];
                ok = v[c];
            end else if (m == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (!ok && v[(mp[m] + k) % 4]) begin
                        ok = 1'b1;
                        c  = (mp[m] + k) % 4;
                    end
                end
            end else if (m == 1) begin
                for (int k = 3; k >= 0; k--) begin
                    if (v[k]) begin
                        ok = 1'b1;
                        c  = k;
                    end
                end
            end else begin
                c  = int'(s);
                ok = v[c];
            end
            er = (ld && ok) ? 4'(1 << c) : 4'h0;
            chk($sformatf("m%0d in_ready", m), 32'(rdy[m]), 32'(er));
            if (ld) begin
                e_ov[m] = ok;
                if (ok) begin
                    e_od[m] = d[c*4 +: 4];
                    e_ol[m] = l[c];
                    e_ch[m] = 2'(c);
                    lk[m]   = !l[c];
                    mg[m]   = c;
                    if (l[c] && m == 0) mp[m] = (c + 1) % 4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        sel       = '0;
        out_ready = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("rst m%0d out_valid", m), 32'(ov[m]), 32'd0);
            chk($sformatf("rst m%0d out_data", m), 32'(od[m]), 32'd0);
            chk($sformatf("rst m%0d out_ch", m), 32'(och[m]), 32'd0);
            chk($sformatf("rst m%0d out_last", m), 32'(ol[m]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin single beats, one per clock.
        for (int k = 0; k < 5; k++) begin
            cyc(4'hF, 16'h3210, 4'hF, 2'd0, 1'b1);
            chk("t1 rr out_ch", 32'(och[0]), 32'(k % 4));
            chk("t1 rr out_valid", 32'(ov[0]), 32'd1);
            chk("t1 fp out_ch", 32'(och[1]), 32'd0);
        end

        // Three-beat packet on ch2 while ch0/ch1 compete.
        cyc(4'b0010, 16'h3210, 4'hF, 2'd0, 1'b1);
        cyc(4'b0111, 16'h3A10, 4'b0011, 2'd0, 1'b1);
        chk("t2 beat A", 32'(od[0]), 32'hA);
        chk("t2 ch A", 32'(och[0]), 32'd2);
        cyc(4'b0111, 16'h3B10, 4'b0011, 2'd0, 1'b1);
        chk("t2 beat B", 32'(od[0]), 32'hB);
        chk("t2 ch B", 32'(och[0]), 32'd2);
        cyc(4'b0111, 16'h3C10, 4'b0111, 2'd0, 1'b1);
        chk("t2 beat C", 32'(od[0]), 32'hC);
        chk("t2 last C", 32'(ol[0]), 32'd1);
        cyc(4'hF, 16'h3210, 4'hF, 2'd0, 1'b1);
        chk("t2 next ch", 32'(och[0]), 32'd3);

        // Fixed priority: ch1 always beats ch3.
        for (int k = 0; k < 4; k++) begin
            cyc(4'b1010, 16'h3210, 4'hF, 2'd0, 1'b1);
            chk("t3 fp out_ch", 32'(och[1]), 32'd1);
            chk("t3 fp in_ready", 32'(rdy[1]), 32'b0010);
        end

        // Manual select: sel change during a locked packet is ignored.
        cyc(4'b1010, 16'h5060, 4'b0000, 2'd1, 1'b1);
        chk("t4 beat1 ch", 32'(och[2]), 32'd1);
        cyc(4'b1010, 16'h5060, 4'b1010, 2'd3, 1'b1);
        chk("t4 beat2 ch", 32'(och[2]), 32'd1);
        chk("t4 beat2 last", 32'(ol[2]), 32'd1);
        cyc(4'b1010, 16'h5060, 4'b1010, 2'd3, 1'b1);
        chk("t4 next ch", 32'(och[2]), 32'd3);

        // Backpressure holds the output and blocks every input.
        cyc(4'b0001, 16'h000A, 4'b0001, 2'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(4'hF, 16'(($urandom)), 4'hF, 2'd0, 1'b0);
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("t5 m%0d hold", m), 32'(od[m]), 32'hA);
                chk($sformatf("t5 m%0d rdy", m), 32'(rdy[m]), 32'd0);
            end
        end
        cyc(4'b0010, 16'h00B0, 4'b0010, 2'd0, 1'b1);
        chk("t5 resume", 32'(od[0]), 32'hB);

        // Asynchronous reset in the middle of a packet on ch2.
        cyc(4'b0100, 16'h0D00, 4'b0000, 2'd2, 1'b1);
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("t6 m%0d async clr", m), 32'(ov[m]), 32'd0);
        end
        reset_model();
        in_valid = '0;
        in_last  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(4'hF, 16'h3210, 4'hF, 2'd0, 1'b1);
        chk("t6 rr restart", 32'(och[0]), 32'd0);

        // Random traffic against the models.
        for (int k = 0; k < 600; k++) begin
            cyc(4'($urandom), 16'($urandom), 4'($urandom), 2'($urandom),
                $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
